// File: rtl/mod_32bit_seq_pkg.sv
// Shared ALU definitions for the multi-cycle MOD/DIV unit: default widths,
// FSM state encoding and the opcode the ALU result mux uses to select MOD.
package mod_32bit_seq_pkg;

    // Default operand width and the iteration counter width (log2 of it)
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 5;

    // ALU opcode that routes this unit's remainder to the result mux
    localparam logic [3:0] ALU_OP_MOD = 4'hA;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // True on the counter value of the final shift-subtract iteration
    function automatic logic last_iter(input logic [DEF_CNT_W-1:0] cnt);
        return cnt == DEF_CNT_W'(DEF_WIDTH - 1);
    endfunction

endpackage

// File: rtl/mod_32bit_dp.sv
// Restoring shift-subtract datapath: divisor register, partial remainder and
// dividend/quotient shift registers, trial subtractor and result registers.
// Sequenced by load/step/finish strobes from mod_32bit_seq.
module mod_32bit_dp
    import mod_32bit_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_b_zero,
    input  logic             i_step,
    input  logic             i_finish,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_remainder,
    output logic [WIDTH-1:0] o_quotient,
    output logic             o_div_by_zero
);

    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_prem;
    logic [WIDTH-1:0] r_dq;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_borrow;
    logic [WIDTH-1:0] w_prem_nxt;
    logic [WIDTH-1:0] w_dq_nxt;

    // The shifted partial remainder keeps prem's MSB as a 33rd bit: with a
    // divisor above 2^31 the partial remainder can have bit 31 set, and
    // dropping it would corrupt both the compare and the result.
    assign w_shift = {r_prem, r_dq[WIDTH-1]};

    // Extra guard bit makes the subtract signed-safe, so a negative trial is
    // never mistaken for a large positive one.
    assign w_trial = {1'b0, w_shift} - {2'b00, r_div};

    // A successful trial is always below the divisor and so fits in WIDTH
    // bits; any set bit above that means the shifted value was too small.
    assign w_borrow = |w_trial[WIDTH+1:WIDTH];

    // Next partial remainder and quotient bit for one iteration
    always_comb begin
        w_prem_nxt = w_trial[WIDTH-1:0];
        w_dq_nxt   = {r_dq[WIDTH-2:0], 1'b1};
        if (w_borrow) begin
            w_prem_nxt = w_shift[WIDTH-1:0];
            w_dq_nxt   = {r_dq[WIDTH-2:0], 1'b0};
        end
    end

    // Working registers: load operands on accept, shift once per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_prem <= '0;
            r_dq   <= '0;
        end else if (i_load) begin
            r_div  <= i_b;
            r_prem <= '0;
            r_dq   <= i_a;
        end else if (i_step) begin
            r_prem <= w_prem_nxt;
            r_dq   <= w_dq_nxt;
        end
    end

    // Result registers: cleared (or given the divide-by-zero answer) on
    // accept, loaded on the final iteration, otherwise held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dbz <= 1'b0;
        end else if (i_load) begin
            if (i_b_zero) begin
                r_rem <= i_a;
                r_quo <= '1;
                r_dbz <= 1'b1;
            end else begin
                r_rem <= '0;
                r_quo <= '0;
                r_dbz <= 1'b0;
            end
        end else if (i_step && i_finish) begin
            r_rem <= w_prem_nxt;
            r_quo <= w_dq_nxt;
        end
    end

    assign o_remainder   = r_rem;
    assign o_quotient    = r_quo;
    assign o_div_by_zero = r_dbz;

endmodule

// File: rtl/mod_32bit_seq.sv
// Multi-cycle unsigned remainder/quotient unit for the ALU MOD opcode.
// One quotient bit per cycle; start/ready/busy/done handshake with the ALU
// control unit. Sequencer and iteration counter live here, arithmetic in
// mod_32bit_dp.
module mod_32bit_seq
    import mod_32bit_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] quotient
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic             w_b_zero;
    logic             w_load;
    logic             w_step;
    logic             w_last;

    assign w_b_zero = (B == '0);
    assign w_load   = (r_state == ST_IDLE) && start;
    assign w_step   = (r_state == ST_CALC);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Sequencer: IDLE -> CALC (32 iterations) -> FIN (one-cycle done) -> IDLE;
    // a zero divisor skips straight to FIN. Handshake outputs are registered
    // alongside the state so they always match it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        if (w_b_zero) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_CALC;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    mod_32bit_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk           (clk),
        .rst_n         (reset_n),
        .i_load        (w_load),
        .i_b_zero      (w_b_zero),
        .i_step        (w_step),
        .i_finish      (w_last),
        .i_a           (A),
        .i_b           (B),
        .o_remainder   (remainder),
        .o_quotient    (quotient),
        .o_div_by_zero (div_by_zero)
    );

    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_mod_32bit_seq.sv
// Directed bench for mod_32bit_seq: hand-computed remainder/quotient vectors,
// handshake timing, ignored starts, async reset mid-operation, held start.
module tb_mod_32bit_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        ready;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] remainder;
    logic [31:0] quotient;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mod_32bit_seq dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .remainder   (remainder),
        .quotient    (quotient)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One operation with start pulsed for a single cycle. exp_lat is the
    // number of clock edges after the accept edge before done is seen.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic [31:0] exp_q,
                         input logic exp_z, input int exp_lat);
        int n;
        int busy_n;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        busy_n = 0;
        @(negedge clk);
        if (b != 0) begin
            chk({tag, ".clr_rem"}, remainder, 32'd0);
            chk({tag, ".clr_quo"}, quotient, 32'd0);
            chk({tag, ".clr_dbz"}, 32'(div_by_zero), 32'd0);
        end
        while (!done && n < 60) begin
            if (busy) busy_n++;
            @(negedge clk);
            n++;
        end
        chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
        chk({tag, ".rem"}, remainder, exp_r);
        chk({tag, ".quo"}, quotient, exp_q);
        chk({tag, ".dbz"}, 32'(div_by_zero), 32'(exp_z));
        chk({tag, ".ready_fin"}, 32'(ready), 32'd0);
        if (b != 0) chk({tag, ".busy_cyc"}, 32'(busy_n), 32'd32);
        @(negedge clk);
        chk({tag, ".done_off"}, 32'(done), 32'd0);
        chk({tag, ".ready_back"}, 32'(ready), 32'd1);
        chk({tag, ".rem_hold"}, remainder, exp_r);
    endtask

    initial begin
        int pulses;
        int m;
        logic [31:0] cap_r;
        logic [31:0] cap_q;

        reset_n = 1'b0; start = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.dbz", 32'(div_by_zero), 32'd0);
        chk("rst.rem", remainder, 32'd0);
        chk("rst.quo", quotient, 32'd0);

        do_op("d100_7", 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);
        do_op("dmax_1", 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0, 32);
        do_op("dmax_msb", 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd1, 1'b0, 32);
        do_op("d5_0", 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 0);
        do_op("d9_3", 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 32);
        do_op("d13_13", 32'd13, 32'd13, 32'd0, 32'd1, 1'b0, 32);
        do_op("dhi_big", 32'hFFFFFFFF, 32'hC0000001, 32'h3FFFFFFE, 32'd1, 1'b0, 32);

        // Second start while busy is ignored; operand changes have no effect
        @(negedge clk);
        A = 32'd7; B = 32'd100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        A = 32'd50; B = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; A = 32'd0; B = 32'd0;
        pulses = 0; cap_r = '1; cap_q = '1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                cap_r = remainder;
                cap_q = quotient;
            end
        end
        chk("ign.pulses", 32'(pulses), 32'd1);
        chk("ign.rem", cap_r, 32'd7);
        chk("ign.quo", cap_q, 32'd0);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        A = 32'd1000; B = 32'd13; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(negedge clk);
        chk("arst.busy_pre", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst.ready", 32'(ready), 32'd1);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.done", 32'(done), 32'd0);
        chk("arst.rem", remainder, 32'd0);
        chk("arst.quo", quotient, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("arst.no_done", 32'(pulses), 32'd0);
        do_op("d1000_13", 32'd1000, 32'd13, 32'd12, 32'd76, 1'b0, 32);

        // start held high: back-to-back operations every 34 cycles
        @(negedge clk);
        A = 32'd20; B = 32'd6; start = 1'b1;
        m = 0;
        while (!done && m < 50) begin
            @(negedge clk);
            m++;
        end
        chk("held.first", 32'(done), 32'd1);
        chk("held.rem1", remainder, 32'd2);
        chk("held.quo1", quotient, 32'd3);
        chk("held.ready_fin", 32'(ready), 32'd0);
        m = 0;
        @(negedge clk);
        m++;
        while (!done && m < 60) begin
            @(negedge clk);
            m++;
        end
        start = 1'b0;
        chk("held.period", 32'(m), 32'd34);
        chk("held.rem2", remainder, 32'd2);
        chk("held.quo2", quotient, 32'd3);
        repeat (2) @(negedge clk);
        chk("held.idle", 32'(ready), 32'd1);
        chk("held.busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
